// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI request fan-in arbiter tree and its lock controller.
// The state encoding and round-robin successor function are used by axi_arb_lock_ctrl.
package axi_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Successor of idx in an n-entry ring; n is a power of two, so N-1 wraps to 0.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/axi_arb_lock_ctrl.sv
// Round-robin pointer and exclusive-lock FSM for a binary fan-in arbiter tree; outputs registered, 1-cycle update.
// No backpressure of its own; optional lock release timeout under AXI_ARB_LOCK_TIMEOUT_EN.
module axi_arb_lock_ctrl
   import axi_arb_pkg::*;
#(
   parameter int N_INIT       = 4,
   parameter int LOG_N_INIT   = $clog2(N_INIT),
   parameter int LOCK_TIMEOUT = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_INIT-1:0]     req_i,
   input  logic                  root_req_i,
   input  logic                  root_gnt_i,
   input  logic [LOG_N_INIT-1:0] root_idx_i,
   input  logic                  root_lock_i,
   output logic [LOG_N_INIT-1:0] RR_FLAG_o,
   output logic                  lock_EXCLUSIVE_o,
   output logic [LOG_N_INIT-1:0] SEL_EXCLUSIVE_o,
   output logic                  lock_owner_valid_o
);

   arb_state_e            state_q, state_d;
   logic [LOG_N_INIT-1:0] rr_q, rr_d;
   logic [LOG_N_INIT-1:0] owner_q, owner_d;
   logic                  hs;
   logic [LOG_N_INIT-1:0] idx_succ;
   logic [LOG_N_INIT-1:0] owner_succ;

   assign hs         = root_req_i & root_gnt_i;
   assign idx_succ   = LOG_N_INIT'(rr_next(int'(root_idx_i), N_INIT));
   assign owner_succ = LOG_N_INIT'(rr_next(int'(owner_q), N_INIT));

`ifdef AXI_ARB_LOCK_TIMEOUT_EN
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(LOCK_TIMEOUT);
   logic [TW-1:0] tmo_q, tmo_d;
`endif

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      owner_d = owner_q;
`ifdef AXI_ARB_LOCK_TIMEOUT_EN
      tmo_d   = tmo_q;
`endif
      if (state_q == IDLE) begin
         if (hs && root_lock_i) begin
            state_d = LOCKED;
            owner_d = root_idx_i;
`ifdef AXI_ARB_LOCK_TIMEOUT_EN
            tmo_d   = TMO_LOAD;
`endif
         end else if (hs) begin
            rr_d = idx_succ;
         end
      end else begin
         if (hs && root_lock_i) begin
`ifdef AXI_ARB_LOCK_TIMEOUT_EN
            tmo_d = TMO_LOAD;
`endif
         end else if (hs) begin
            // Owner's non-exclusive access closes the sequence; fairness resumes after it.
            state_d = IDLE;
            rr_d    = owner_succ;
         end
`ifdef AXI_ARB_LOCK_TIMEOUT_EN
         else if (tmo_q == '0) begin
            state_d = IDLE;
            rr_d    = owner_succ;
         end else begin
            tmo_d = tmo_q - TW'(1);
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
      end
   end

`ifdef AXI_ARB_LOCK_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

   assign RR_FLAG_o          = rr_q;
   assign SEL_EXCLUSIVE_o    = owner_q;
   assign lock_EXCLUSIVE_o   = (state_q == LOCKED);
   assign lock_owner_valid_o = (state_q == LOCKED);

   // The tree is pinned while locked, so any other winner means the tree or initiator broke protocol.
   a_locked_winner_is_owner: assert property (@(posedge clk) disable iff (rst)
      (state_q == LOCKED && hs) |-> (root_idx_i == owner_q));

   a_winner_requests: assert property (@(posedge clk) disable iff (rst)
      hs |-> req_i[root_idx_i]);

   a_param_sane: assert property (@(posedge clk)
      (N_INIT >= 2) && ((N_INIT & (N_INIT - 1)) == 0) && (LOCK_TIMEOUT >= 2));

endmodule

// File: tb/tb_axi_arb_lock_ctrl.sv
// Directed bench for axi_arb_lock_ctrl: expected outputs queued with each stimulus step, checked after the edge.
module tb_axi_arb_lock_ctrl;

   localparam int N  = 4;
   localparam int LW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_i = '0;
   logic          root_req_i = 1'b0;
   logic          root_gnt_i = 1'b0;
   logic [LW-1:0] root_idx_i = '0;
   logic          root_lock_i = 1'b0;
   logic [LW-1:0] rr_flag;
   logic          lock_excl;
   logic [LW-1:0] sel_excl;
   logic          owner_vld;

   typedef struct {
      string         tag;
      logic [LW-1:0] rr;
      logic          lock;
      logic [LW-1:0] sel;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   axi_arb_lock_ctrl #(
      .N_INIT(N),
      .LOG_N_INIT(LW),
      .LOCK_TIMEOUT(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_i(req_i),
      .root_req_i(root_req_i),
      .root_gnt_i(root_gnt_i),
      .root_idx_i(root_idx_i),
      .root_lock_i(root_lock_i),
      .RR_FLAG_o(rr_flag),
      .lock_EXCLUSIVE_o(lock_excl),
      .SEL_EXCLUSIVE_o(sel_excl),
      .lock_owner_valid_o(owner_vld)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input exp_t e);
      chk({e.tag, ".rr"},   32'(rr_flag),   32'(e.rr));
      chk({e.tag, ".lock"}, 32'(lock_excl), 32'(e.lock));
      chk({e.tag, ".sel"},  32'(sel_excl),  32'(e.sel));
      chk({e.tag, ".vld"},  32'(owner_vld), 32'(e.lock));
   endtask

   task automatic pop_and_check();
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = exp_q.pop_front();
         check_outputs(e);
      end
   endtask

   // One cycle with a root handshake for initiator idx.
   task automatic hs_step(input string tag, input logic [LW-1:0] idx, input logic lk,
                          input logic [LW-1:0] e_rr, input logic e_lock, input logic [LW-1:0] e_sel);
      exp_t e;
      req_i       = N'($urandom) | (N'(1) << idx);
      root_req_i  = 1'b1;
      root_gnt_i  = 1'b1;
      root_idx_i  = idx;
      root_lock_i = lk;
      e.tag = tag; e.rr = e_rr; e.lock = e_lock; e.sel = e_sel;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      root_gnt_i = 1'b0;
      root_req_i = 1'b0;
      pop_and_check();
   endtask

   // One cycle without handshake; requests wiggle but the grant stays low.
   task automatic idle_step(input string tag,
                            input logic [LW-1:0] e_rr, input logic e_lock, input logic [LW-1:0] e_sel);
      exp_t e;
      req_i       = N'($urandom);
      root_req_i  = 1'($urandom);
      root_gnt_i  = 1'b0;
      root_idx_i  = LW'($urandom);
      root_lock_i = 1'($urandom);
      e.tag = tag; e.rr = e_rr; e.lock = e_lock; e.sel = e_sel;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      pop_and_check();
   endtask

   initial begin
      exp_t r;
      @(posedge clk);
      #1;
      r.tag = "reset"; r.rr = '0; r.lock = 1'b0; r.sel = '0;
      check_outputs(r);
      rst = 1'b0;

      // Round-robin wrap 3 -> 0, then 0 -> 1.
      hs_step("rr_wrap",  2'd3, 1'b0, 2'd0, 1'b0, 2'd0);
      hs_step("rr_next",  2'd0, 1'b0, 2'd1, 1'b0, 2'd0);
      // Lock entry keeps the pointer.
      hs_step("lock_in",  2'd2, 1'b1, 2'd1, 1'b1, 2'd2);

`ifdef AXI_ARB_LOCK_TIMEOUT_EN
      for (int i = 0; i < 4; i++) idle_step("pre_refresh_hold", 2'd1, 1'b1, 2'd2);
      hs_step("refresh",  2'd2, 1'b1, 2'd1, 1'b1, 2'd2);
      for (int i = 0; i < 4; i++) idle_step("post_refresh_hold", 2'd1, 1'b1, 2'd2);
      idle_step("refresh_expire", 2'd3, 1'b0, 2'd2);
      hs_step("relock",   2'd2, 1'b1, 2'd3, 1'b1, 2'd2);
`else
      for (int i = 0; i < 10; i++) idle_step("lock_hold", 2'd1, 1'b1, 2'd2);
      hs_step("refresh",  2'd2, 1'b1, 2'd1, 1'b1, 2'd2);
`endif

      hs_step("release",  2'd2, 1'b0, 2'd3, 1'b0, 2'd2);
      idle_step("idle_hold", 2'd3, 1'b0, 2'd2);

      hs_step("lock_own1", 2'd1, 1'b1, 2'd3, 1'b1, 2'd1);
`ifdef AXI_ARB_LOCK_TIMEOUT_EN
      for (int i = 0; i < 4; i++) idle_step("tmo_hold", 2'd3, 1'b1, 2'd1);
      idle_step("tmo_release", 2'd2, 1'b0, 2'd1);
`else
      for (int i = 0; i < 999; i++) idle_step("long_hold", 2'd3, 1'b1, 2'd1);
      idle_step("long_hold_end", 2'd3, 1'b1, 2'd1);
      hs_step("release1", 2'd1, 1'b0, 2'd2, 1'b0, 2'd1);
`endif

      // Lock owner 3, then reset asynchronously between edges.
      hs_step("lock_own3", 2'd3, 1'b1, 2'd2, 1'b1, 2'd3);
      #1;
      rst = 1'b1;
      #2;
      r.tag = "async_rst"; r.rr = '0; r.lock = 1'b0; r.sel = '0;
      check_outputs(r);
      @(posedge clk);
      #1;
      rst = 1'b0;
      hs_step("post_rst_hs", 2'd0, 1'b0, 2'd1, 1'b0, 2'd0);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_arb_lock_ctrl.md
# axi_arb_lock_ctrl

Sequential control block for a binary tree of 2-input request fan-in arbiters serving one AXI target port's AW or AR channel. It owns the round-robin pointer that drives the per-level RR flags of the tree and the exclusive-access lock state machine. While exclusive access is active, the tree is pinned to a single initiator. All outputs are registered and feed the arbiter tree combinationally in the next cycle.

## Interface
- N_INIT, default 4: number of initiator inputs to the tree; power of two, ≥ 2.
- LOG_N_INIT, default $clog2(N_INIT): index width.
- LOCK_TIMEOUT, default 256: release timeout in cycles, ≥ 2; used only with the timeout feature.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_i  in  N_INIT  per-initiator request, ordered as the tree leaves.
- root_req_i  in  1  request at the tree root.
- root_gnt_i  in  1  grant at the tree root; a handshake is root_req_i & root_gnt_i.
- root_idx_i  in  LOG_N_INIT  index of the initiator winning at the root, carried through the tree AUX field.
- root_lock_i  in  1  AxLOCK of the winning request.
- RR_FLAG_o  out  LOG_N_INIT  round-robin pointer; bit k drives every fan-in primitive at tree level k, where level 0 is the leaves.
- lock_EXCLUSIVE_o  out  1  high while LOCKED; each primitive forwards only the selected side.
- SEL_EXCLUSIVE_o  out  LOG_N_INIT  locked owner index; bit k drives SEL_EXCLUSIVE of level k.
- lock_owner_valid_o  out  1  status copy of lock_EXCLUSIVE_o, for performance counters.

## Operation
- State machine with two states: IDLE and LOCKED. Registers: state, rr_q (LOG_N_INIT bits), owner_q (LOG_N_INIT bits), and, with the timeout feature, tmo_q.
- IDLE, handshake with root_lock_i=0: rr_q ← root_idx_i + 1, modulo N_INIT with natural wrap (N-1 → 0).
- IDLE, handshake with root_lock_i=1: move to LOCKED; owner_q ← root_idx_i; rr_q is held.
- LOCKED, handshake with root_lock_i=1: stay in LOCKED; owner_q is unchanged; tmo_q reloads.
- LOCKED, handshake with root_lock_i=0: this is the owner's release access. Move to IDLE; rr_q ← owner_q + 1 (mod N_INIT).
- In LOCKED, root_idx_i always equals owner_q because the tree is pinned. A mismatch is a protocol error and is flagged by assertion only.
- No handshake: all state is held. A req_i pattern alone never changes state.
- Outputs: RR_FLAG_o = rr_q; SEL_EXCLUSIVE_o = owner_q; lock_EXCLUSIVE_o = (state == LOCKED).
- If the owner deasserts req_i while LOCKED, the root request goes low. The lock is held and other initiators are starved. This is intended.

## Timing
- Reset values: RR_FLAG_o=0, SEL_EXCLUSIVE_o=0, lock_EXCLUSIVE_o=0, lock_owner_valid_o=0, state=IDLE, tmo_q=0.
- Latency: a handshake in cycle t updates the outputs at the start of cycle t+1. There is no combinational path from input to output.
- Reset asserted mid-lock: the block returns to IDLE immediately (asynchronously). Any in-flight exclusive sequence is abandoned.
- Reset deassertion: the first handshake may occur in the first cycle after deassertion.

## Configuration
- AXI_ARB_LOCK_TIMEOUT_EN defined:
  - tmo_q, a $clog2(LOCK_TIMEOUT+1)-bit down-counter, loads LOCK_TIMEOUT on entry to LOCKED and on every owner handshake.
  - It decrements each LOCKED cycle without a handshake.
  - When it reaches 0 and no handshake occurs in that cycle, the block moves to IDLE and rr_q ← owner_q + 1.
  - If a handshake coincides with tmo_q=0, the handshake rules apply instead.
- AXI_ARB_LOCK_TIMEOUT_EN undefined: no counter is built, LOCK_TIMEOUT is ignored, and LOCKED exits only via a release handshake.

## Structure
- The shared package axi_arb_pkg holds:
  - the typedef arb_state_e {IDLE, LOCKED};
  - the function rr_next(idx) returning (idx+1) mod N_INIT.
- The block is a single module with no sub-module. The optional timeout counter is an inline always_ff under the macro.

## Test plan
- Round-robin wrap: N_INIT=4; root_idx_i handshakes 3, then 0, with root_lock_i=0 → RR_FLAG_o reads 0 after the first and 1 after the second.
- Lock entry: handshake root_idx_i=2, root_lock_i=1 → next cycle lock_EXCLUSIVE_o=1, SEL_EXCLUSIVE_o=2, RR_FLAG_o unchanged.
- Release: in LOCKED with owner 2, handshake with root_lock_i=0 → next cycle lock_EXCLUSIVE_o=0, RR_FLAG_o=3.
- Lock refresh and hold: in LOCKED, 10 idle cycles, then a root_lock_i=1 handshake → still LOCKED with owner 2. With the timeout feature and LOCK_TIMEOUT=4: 4 idle cycles after a refresh stay LOCKED, and release occurs on the 5th.
- Timeout release: with the macro, LOCK_TIMEOUT=4, owner 1, no handshakes → lock_EXCLUSIVE_o=0 exactly 5 cycles after entry, RR_FLAG_o=2. Without the macro, the block is still LOCKED after 1000 cycles.
- Async reset mid-lock: assert rst while LOCKED with owner 3 → all outputs 0 within the same cycle, without waiting for a clk edge.
